// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared constants, FSM states and slot map for the pulse run scheduler
package pulse_pkg;

    localparam int DUR_W = 22;
    localparam int CNT_W = 16;
    localparam int NSLOT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    // Slots 0-7 form the positive polarity half, 8-15 the negative half.
    localparam logic [3:0] SLOT_RPOS  = 4'd0;
    localparam logic [3:0] SLOT_PPOS0 = 4'd1;
    localparam logic [3:0] SLOT_MPOS1 = 4'd2;
    localparam logic [3:0] SLOT_PPOS1 = 4'd3;
    localparam logic [3:0] SLOT_WPOS  = 4'd4;
    localparam logic [3:0] SLOT_PPOS2 = 4'd5;
    localparam logic [3:0] SLOT_PPOS3 = 4'd6;
    localparam logic [3:0] SLOT_MPOS2 = 4'd7;
    localparam logic [3:0] SLOT_RNEG  = 4'd8;
    localparam logic [3:0] SLOT_PNEG0 = 4'd9;
    localparam logic [3:0] SLOT_MNEG1 = 4'd10;
    localparam logic [3:0] SLOT_PNEG1 = 4'd11;
    localparam logic [3:0] SLOT_WNEG  = 4'd12;
    localparam logic [3:0] SLOT_PNEG2 = 4'd13;
    localparam logic [3:0] SLOT_PNEG3 = 4'd14;
    localparam logic [3:0] SLOT_MNEG2 = 4'd15;

    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

endpackage

// File: rtl/pulse_dur_bank.sv
// rtl/pulse_dur_bank.sv - shadow/active duration banks with commit copy
// Optional readback port under PULSE_SCHED_READBACK_EN.
module pulse_dur_bank
    import pulse_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [DUR_W-1:0] wr_data,
    input  logic             copy,
    input  logic [3:0]       act_idx,
    output logic [DUR_W-1:0] act_dur
`ifdef PULSE_SCHED_READBACK_EN
    ,
    input  logic [3:0]       rd_addr,
    input  logic             rd_sel,
    output logic [31:0]      rd_data
`endif
);

    logic [DUR_W-1:0] shadow_q [NSLOT];
    logic [DUR_W-1:0] shadow_d [NSLOT];
    logic [DUR_W-1:0] active_q [NSLOT];
    logic [DUR_W-1:0] active_d [NSLOT];

    // The copy reads shadow_q, so a same-cycle write is left for a later commit.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
        end
        if (copy) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NSLOT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign act_dur = active_q[act_idx];

`ifdef PULSE_SCHED_READBACK_EN
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    always_comb begin
        rd_data_d = {{(32-DUR_W){1'b0}}, (rd_sel ? active_q[rd_addr] : shadow_q[rd_addr])};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/pulse_run_scheduler.sv
// rtl/pulse_run_scheduler.sv - 16-slot pulse sequence scheduler (FSM, slot timer, sequence counter)
// Optional readback port under PULSE_SCHED_READBACK_EN.
module pulse_run_scheduler
    import pulse_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             commit,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic [CNT_W-1:0] seq_target,
`ifdef PULSE_SCHED_READBACK_EN
    input  logic [3:0]       rd_addr,
    input  logic             rd_sel,
    output logic [31:0]      rd_data,
`endif
    output logic [3:0]       slot_idx,
    output logic             slot_start,
    output logic [DUR_W-1:0] slot_dur,
    output logic             run_active,
    output logic [CNT_W-1:0] seq_count,
    output logic             commit_pending,
    output logic             done
);

    sched_state_e     state_q, state_d;
    logic [3:0]       slot_idx_q, slot_idx_d;
    logic [DUR_W-1:0] timer_q, timer_d;
    logic             slot_start_q, slot_start_d;
    logic [CNT_W-1:0] seq_count_q, seq_count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             pend_q, pend_d;
    logic             done_q, done_d;
    logic             copy;
    logic [DUR_W-1:0] act_dur;
    logic [DUR_W-1:0] cur_dur;
    logic             slot_last;
    logic             seq_last;
    logic             wr_data_unused;

    assign wr_data_unused = ^wr_data[31:DUR_W];

    pulse_dur_bank u_bank (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data[DUR_W-1:0]),
        .copy     (copy),
        .act_idx  (slot_idx_q),
        .act_dur  (act_dur)
`ifdef PULSE_SCHED_READBACK_EN
        ,
        .rd_addr  (rd_addr),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data)
`endif
    );

    assign cur_dur   = eff_dur(act_dur);
    assign slot_last = (timer_q == cur_dur);
    assign seq_last  = slot_last && (slot_idx_q == SLOT_MNEG2);

    always_comb begin
        state_d      = state_q;
        slot_idx_d   = slot_idx_q;
        timer_d      = timer_q;
        slot_start_d = 1'b0;
        seq_count_d  = seq_count_q;
        target_d     = target_q;
        pend_d       = pend_q;
        done_d       = 1'b0;
        copy         = 1'b0;

        case (state_q)
            IDLE: begin
                copy = commit;
                if (start && !abort) begin
                    state_d      = RUN;
                    slot_idx_d   = SLOT_RPOS;
                    slot_start_d = 1'b1;
                    timer_d      = DUR_W'(1);
                    seq_count_d  = '0;
                    target_d     = seq_target;
                end
            end
            RUN, DRAIN: begin
                if (abort) begin
                    state_d    = IDLE;
                    slot_idx_d = SLOT_RPOS;
                    timer_d    = '0;
                    done_d     = 1'b1;
                    copy       = pend_q || commit;
                    pend_d     = 1'b0;
                end else begin
                    if (state_q == RUN && stop) begin
                        state_d = DRAIN;
                    end
                    if (commit) begin
                        pend_d = 1'b1;
                    end
                    if (slot_last) begin
                        timer_d      = DUR_W'(1);
                        slot_idx_d   = slot_idx_q + 4'd1;
                        slot_start_d = 1'b1;
                    end else begin
                        timer_d = timer_q + DUR_W'(1);
                    end
                    // Sequence boundary: count, apply any deferred commit, decide whether to end.
                    if (seq_last) begin
                        seq_count_d = (&seq_count_q) ? seq_count_q : seq_count_q + CNT_W'(1);
                        copy        = pend_q || commit;
                        pend_d      = 1'b0;
                        if ((target_q != '0 && seq_count_d == target_q) ||
                            state_q == DRAIN || stop) begin
                            state_d      = IDLE;
                            slot_idx_d   = SLOT_RPOS;
                            slot_start_d = 1'b0;
                            timer_d      = '0;
                            done_d       = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            slot_idx_q   <= '0;
            timer_q      <= '0;
            slot_start_q <= 1'b0;
            seq_count_q  <= '0;
            target_q     <= '0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_idx_q   <= slot_idx_d;
            timer_q      <= timer_d;
            slot_start_q <= slot_start_d;
            seq_count_q  <= seq_count_d;
            target_q     <= target_d;
            pend_q       <= pend_d;
            done_q       <= done_d;
        end
    end

    // In IDLE the raw stored slot 0 value is shown, so reset reads back as zero.
    assign slot_dur       = (state_q == IDLE) ? act_dur : cur_dur;
    assign slot_idx       = slot_idx_q;
    assign slot_start     = slot_start_q;
    assign run_active     = (state_q != IDLE);
    assign seq_count      = seq_count_q;
    assign commit_pending = pend_q;
    assign done           = done_q;

endmodule

// File: tb/tb_pulse_run_scheduler.sv
// tb/tb_pulse_run_scheduler.sv - directed self-checking bench for pulse_run_scheduler
module tb_pulse_run_scheduler;
    import pulse_pkg::*;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             commit;
    logic             start;
    logic             stop;
    logic             abort;
    logic [CNT_W-1:0] seq_target;
    logic [3:0]       slot_idx;
    logic             slot_start;
    logic [DUR_W-1:0] slot_dur;
    logic             run_active;
    logic [CNT_W-1:0] seq_count;
    logic             commit_pending;
    logic             done;
`ifdef PULSE_SCHED_READBACK_EN
    logic [3:0]       rd_addr = '0;
    logic             rd_sel = 1'b0;
    logic [31:0]      rd_data;
`endif

    always #5 clk_in = ~clk_in;

    pulse_run_scheduler dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .start          (start),
        .stop           (stop),
        .abort          (abort),
        .seq_target     (seq_target),
`ifdef PULSE_SCHED_READBACK_EN
        .rd_addr        (rd_addr),
        .rd_sel         (rd_sel),
        .rd_data        (rd_data),
`endif
        .slot_idx       (slot_idx),
        .slot_start     (slot_start),
        .slot_dur       (slot_dur),
        .run_active     (run_active),
        .seq_count      (seq_count),
        .commit_pending (commit_pending),
        .done           (done)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    int st_cyc [64];
    int st_idx [64];
    int st_dur [64];
    int n_st;
    int done_cyc;
    int cp [512];
    int ra [512];
    int sc [512];
    int ix [512];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk_in);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 32'(d);
        @(negedge clk_in);
        wr_en = 1'b0;
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < 16; i++) wr(i, d);
    endtask

    task automatic do_commit();
        @(negedge clk_in); commit = 1'b1;
        @(negedge clk_in); commit = 1'b0;
    endtask

    task automatic do_start(input int tgt);
        seq_target = CNT_W'(tgt);
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_idx"}, 32'(slot_idx), 0);
        check_eq({tag, "_start"}, 32'(slot_start), 0);
        check_eq({tag, "_dur"}, 32'(slot_dur), 0);
        check_eq({tag, "_active"}, 32'(run_active), 0);
        check_eq({tag, "_count"}, 32'(seq_count), 0);
        check_eq({tag, "_pend"}, 32'(commit_pending), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
    endtask

    // act: 0 none, 1 stop, 2 abort, 3 reset, 4 write slot0=10 then commit next cycle
    task automatic watch(input int maxc, input int act, input int act_slot);
        bit acted = 0;
        bit pend_wr = 0;
        n_st = 0;
        done_cyc = -1;
        for (int c = 0; c < maxc; c++) begin
            if (c > 0) begin
                @(negedge clk_in);
                stop = 1'b0; abort = 1'b0; commit = 1'b0; wr_en = 1'b0;
                if (pend_wr) begin commit = 1'b1; pend_wr = 0; end
            end
            cp[c] = int'(commit_pending);
            ra[c] = int'(run_active);
            sc[c] = int'(seq_count);
            ix[c] = int'(slot_idx);
            if (slot_start && n_st < 64) begin
                st_cyc[n_st] = c; st_idx[n_st] = int'(slot_idx); st_dur[n_st] = int'(slot_dur);
                n_st++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (!acted && act != 0 && slot_start && int'(slot_idx) == act_slot) begin
                acted = 1;
                case (act)
                    1: stop = 1'b1;
                    2: abort = 1'b1;
                    3: begin rst_n_in = 1'b0; #1; return; end
                    default: begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd10; pend_wr = 1; end
                endcase
            end
        end
        stop = 1'b0; abort = 1'b0; commit = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation bound exceeded");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n_in = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; seq_target = '0;
        tick(3);
        check_zero_outputs("reset");
        @(negedge clk_in); rst_n_in = 1'b1;

        // Basic run: all slots 3, two sequences
        fill(3);
        do_commit();
        check_eq("idle_dur_after_commit", 32'(slot_dur), 3);
        check_eq("idle_pend", 32'(commit_pending), 0);
        do_start(2);
        watch(200, 0, 0);
        check_eq("basic_nstarts", n_st, 32);
        bad = 0;
        for (int i = 0; i < 31; i++) if (st_cyc[i+1] - st_cyc[i] != 3) bad++;
        check_eq("basic_gap_errors", bad, 0);
        check_eq("basic_idx15", st_idx[15], 15);
        check_eq("basic_wrap_idx0", st_idx[16], 0);
        check_eq("basic_done_cyc", done_cyc, 96);
        check_eq("basic_cnt47", sc[47], 0);
        check_eq("basic_cnt48", sc[48], 1);
        check_eq("basic_cnt_done", sc[96], 2);
        check_eq("basic_active95", ra[95], 1);
        check_eq("basic_active_done", ra[96], 0);
        tick(1);
        check_eq("basic_done_one_cycle", 32'(done), 0);

        // Zero-duration slot 5
        for (int i = 0; i < 16; i++) wr(i, (i == 5) ? 0 : 2);
        do_commit();
        do_start(1);
        watch(100, 0, 0);
        check_eq("zero_slot5_cyc", st_cyc[5], 10);
        check_eq("zero_slot6_cyc", st_cyc[6], 11);
        check_eq("zero_slot5_dur", st_dur[5], 1);
        check_eq("zero_slot4_dur", st_dur[4], 2);
        check_eq("zero_idx10", ix[10], 5);
        check_eq("zero_idx11", ix[11], 6);
        check_eq("zero_done_cyc", done_cyc, 31);

        // Deferred commit while running forever
        fill(4);
        do_commit();
        do_start(0);
        watch(80, 4, 2);
        check_eq("defer_pend9", cp[9], 0);
        check_eq("defer_pend10", cp[10], 1);
        check_eq("defer_pend63", cp[63], 1);
        check_eq("defer_pend64", cp[64], 0);
        check_eq("defer_slot0_cyc", st_cyc[16], 64);
        check_eq("defer_slot0_dur", st_dur[16], 10);
        check_eq("defer_slot1_cyc", st_cyc[17], 74);
        check_eq("defer_cnt64", sc[64], 1);
        check_eq("defer_no_done", done_cyc, -1);
        @(negedge clk_in); abort = 1'b1;
        @(negedge clk_in); abort = 1'b0;
        check_eq("abort_forever_active", 32'(run_active), 0);
        check_eq("abort_forever_done", 32'(done), 1);
        check_eq("abort_forever_idx", 32'(slot_idx), 0);
        tick(1);
        check_eq("abort_forever_done_clr", 32'(done), 0);

        // Graceful stop in slot 7
        fill(2);
        do_commit();
        do_start(0);
        watch(100, 1, 7);
        check_eq("stop_done_cyc", done_cyc, 32);
        check_eq("stop_nstarts", n_st, 16);
        check_eq("stop_drain_active", ra[31], 1);
        check_eq("stop_cnt", sc[32], 1);
        check_eq("stop_idle", ra[32], 0);

        // Abort in slot 7
        do_start(0);
        watch(100, 2, 7);
        check_eq("abort_done_cyc", done_cyc, 15);
        check_eq("abort_active", ra[15], 0);
        check_eq("abort_idx", ix[15], 0);
        check_eq("abort_nstarts", n_st, 8);

        // Start with abort in IDLE
        @(negedge clk_in); start = 1'b1; abort = 1'b1;
        @(negedge clk_in); start = 1'b0; abort = 1'b0;
        check_eq("startabort_active", 32'(run_active), 0);
        check_eq("startabort_done", 32'(done), 0);
        check_eq("startabort_start", 32'(slot_start), 0);

        // Write and commit in the same cycle keep the old active value
        @(negedge clk_in); wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd7; commit = 1'b1;
        @(negedge clk_in); wr_en = 1'b0; commit = 1'b0;
        do_start(1);
        watch(100, 0, 0);
        check_eq("wrcommit_old_slot3", st_cyc[4] - st_cyc[3], 2);
        check_eq("wrcommit_done_cyc", done_cyc, 32);
        do_commit();
        do_start(1);
        watch(100, 0, 0);
        check_eq("wrcommit_new_slot3", st_cyc[4] - st_cyc[3], 7);
        check_eq("wrcommit_new_done_cyc", done_cyc, 37);

        // Asynchronous reset in slot 9
        do_start(0);
        watch(100, 3, 9);
        check_eq("rst_no_done_before", done_cyc, -1);
        check_zero_outputs("async_rst");
        tick(2);
        check_eq("rst_no_done_after", 32'(done), 0);
        rst_n_in = 1'b1;
        tick(1);
        check_eq("rst_release_active", 32'(run_active), 0);
        check_eq("rst_release_dur", 32'(slot_dur), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pulse_run_scheduler.md
Name: pulse_run_scheduler

Overview:
- Owns the 16-slot pulse duration table: reset, pause, measure and write slots, in positive and negative polarity halves.
- Sequences slot-by-slot playback for a bounded or unbounded number of full sequences.
- Host writes go to a shadow bank; a commit copies the shadow bank into the active bank, either immediately when idle or at the next sequence boundary when running.
- Downstream, the pulse output stage consumes slot_idx, slot_start and run_active to drive signal_out and the trigger outputs.

Parameters:
- DUR_W, 22: width of a slot duration and of the slot timer.
- CNT_W, 16: width of the sequence-count target and the sequence counter.
- NSLOT, 16: slots per sequence. Fixed; slot_idx is 4 bits.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- wr_en  in  1  shadow-table write strobe.
- wr_addr  in  4  slot index to write.
- wr_data  in  32  duration; bits [DUR_W-1:0] are used, upper bits ignored.
- commit  in  1  one-cycle request to copy shadow into active.
- start  in  1  one-cycle run request.
- stop  in  1  graceful stop: finish the current sequence, then stop.
- abort  in  1  immediate stop.
- seq_target  in  CNT_W  number of sequences per run; 0 means run forever.
- slot_idx  out  4  current slot.
- slot_start  out  1  one-cycle pulse on the first cycle of each slot.
- slot_dur  out  DUR_W  effective duration of the current slot.
- run_active  out  1  high while in RUN or DRAIN.
- seq_count  out  CNT_W  number of completed sequences in this run.
- commit_pending  out  1  a commit is waiting for a sequence boundary.
- done  out  1  one-cycle pulse when a run ends by any path.

Behaviour:
- Reset values: all outputs 0; shadow and active banks all 0; FSM in IDLE.
- Effective duration: a stored value of 0 is treated as 1. Slot k occupies exactly max(dur_k,1) cycles.
- Write: on the cycle wr_en is high, shadow[wr_addr] <= wr_data[DUR_W-1:0]. Writes are accepted in every state.
- Commit in IDLE: active <= shadow on the next edge; commit_pending stays 0.
- Commit in RUN or DRAIN:
  - commit_pending is set.
  - The copy happens on the last cycle of slot 15; commit_pending then clears.
  - Slot 0 of the next sequence uses the new values.
- Write and commit in the same cycle: the copy takes the pre-write shadow contents. The new write remains in shadow for a later commit.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN when start is high.
  - Seq_count is cleared.
  - Slot 0 begins on the next cycle: slot_idx=0 and slot_start=1.
  - seq_target is latched at start; later changes to it are ignored until the next start.
- RUN slot timing:
  - The slot timer counts 1..dur.
  - At terminal count, slot_idx advances to the next slot; after slot 15 it wraps to 0.
  - slot_start pulses on the following cycle.
- Sequence completion:
  - On the last cycle of slot 15, seq_count increments; it saturates at all-ones.
  - If the latched target is nonzero and the new count equals it, the FSM goes to IDLE and done pulses on that edge.
- RUN -> DRAIN on stop. DRAIN behaves like RUN but ends in IDLE after slot 15, pulsing done.
- Stop in IDLE is ignored. Stop in DRAIN is ignored.
- Abort from RUN or DRAIN:
  - Next edge: IDLE; run_active=0; slot_idx=0; done pulses.
  - commit_pending is kept, and its copy is performed in IDLE on that same edge.
- Abort in IDLE: no effect.
- Priority when several controls arrive together: abort > stop > start.
- Start while running is ignored.
- In IDLE: slot_start=0 and slot_idx=0. slot_dur shows the active bank entry for slot 0.
- Reset mid-run: everything returns to reset values asynchronously; no done pulse.

Optional Feature:
- Macro: PULSE_SCHED_READBACK_EN.
- When defined, add:
  - rd_addr, input, 4 bits.
  - rd_sel, input, 1 bit: 0 = shadow bank, 1 = active bank.
  - rd_data, output, 32 bits: registered, one-cycle latency, zero-extended.
- When not defined, these ports are absent and no read mux is built.

Decomposition:
- Shared package pulse_pkg:
  - DUR_W, CNT_W, NSLOT.
  - FSM state enum {IDLE, RUN, DRAIN}.
  - Named slot constants: SLOT_RPOS=0 … SLOT_MNEG2=15, giving the polarity-half map.
- Sub-module pulse_dur_bank: shadow and active register arrays, write port, commit copy, and the optional read mux. The FSM and timer stay in the top module.

Test Plan:
- Basic run:
  - Write all slots = 3, commit in IDLE, seq_target=2, start.
  - Expect 16 slot_start pulses spaced 3 cycles apart per sequence.
  - Expect seq_count 1 then 2, then done one cycle after slot 15 of the second sequence, and run_active low.
- Zero-duration slot:
  - Set slot 5 = 0 and all others = 2.
  - Expect slot 5 to last 1 cycle and slot_dur=1 while slot_idx=5.
- Deferred commit:
  - While running seq_target=0 with all slots = 4, write slot 0 = 10 and commit.
  - Expect commit_pending high until the end of slot 15, and the next slot 0 to last 10 cycles.
- Graceful stop and abort:
  - Stop during slot 7: expect slots 8–15 to complete, then done.
  - Repeat with abort during slot 7: expect IDLE next cycle and done.
- Simultaneous controls:
  - Start and abort in the same cycle in IDLE: expect it to remain IDLE.
  - Write to slot 3 plus commit in the same cycle: active[3] keeps its old value and shadow[3] holds the new one.
- Async reset mid-slot 9: expect all outputs 0 immediately and no done pulse.
